// File: rtl/fma16_sched_pkg.sv
// fma16_sched_pkg: opcodes, datapath control decode and constants shared by the fma16 scheduler
package fma16_sched_pkg;
  typedef enum logic [2:0] {
    OP_FADD   = 3'd0,
    OP_FSUB   = 3'd1,
    OP_FMUL   = 3'd2,
    OP_FMADD  = 3'd3,
    OP_FMSUB  = 3'd4,
    OP_FNMADD = 3'd5,
    OP_FNMSUB = 3'd6,
    OP_ILL    = 3'd7
  } op_e;
  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } fma_ctl_t;
  localparam logic [15:0] CANON_NAN = 16'h7E00;
  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RP  = 2'b10;
  localparam logic [1:0] RM_RN  = 2'b11;
  function automatic fma_ctl_t op2ctl(input op_e op);
    return op == OP_FADD   ? fma_ctl_t'(4'b0100) :
           op == OP_FSUB   ? fma_ctl_t'(4'b0101) :
           op == OP_FMUL   ? fma_ctl_t'(4'b1000) :
           op == OP_FMADD  ? fma_ctl_t'(4'b1100) :
           op == OP_FMSUB  ? fma_ctl_t'(4'b1101) :
           op == OP_FNMADD ? fma_ctl_t'(4'b1110) :
           op == OP_FNMSUB ? fma_ctl_t'(4'b1111) : fma_ctl_t'(4'b0000);
  endfunction
endpackage

// File: rtl/fma16.sv
// fma16: combinational half-precision (+/-)(x*y or x) (+/-)z with a single rounding
module fma16 import fma16_sched_pkg::*; (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negr,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result
);
  logic [15:0] ye, ze;
  logic [79:0] pm;
  logic [80:0] zm, mag, rmask;
  logic ps, zs, s, sub, pbig, nan, pinf, zinf, guard, stk, rnz, inc, toinf, ovf;
  logic [6:0] lead, lsb;
  logic [11:0] q;
  logic [16:0] enc;
  // magnitude as an exact integer in units of 2^-24
  function automatic logic [39:0] fix(input logic [15:0] h);
    return {29'd0, |h[14:10], h[9:0]} << (|h[14:10] ? h[14:10] - 5'd1 : 5'd0);
  endfunction
  function automatic logic is_inf(input logic [15:0] h);
    return &h[14:10] & ~|h[9:0];
  endfunction
  function automatic logic is_nan(input logic [15:0] h);
    return &h[14:10] & |h[9:0];
  endfunction
  function automatic logic is_zero(input logic [15:0] h);
    return ~|h[14:0];
  endfunction
  // exact fixed-point sum in units of 2^-48, then one normalise-and-round step
  always_comb begin
    ye = mul ? y : 16'h3C00;
    ze = add ? z : 16'h0000;
    ps = x[15] ^ ye[15] ^ negr;
    zs = ze[15] ^ negr ^ negz;
    pm = 80'(fix(x)) * 80'(fix(ye));
    zm = {17'd0, fix(ze), 24'd0};
    sub = ps != zs;
    pbig = {1'b0, pm} >= zm;
    mag = !sub ? {1'b0, pm} + zm : pbig ? {1'b0, pm} - zm : zm - {1'b0, pm};
    s = sub & !pbig ? zs : ps;
    lead = '0;
    for (int i = 0; i < 81; i++) lead = mag[i] ? 7'(i) : lead;
    lsb = lead >= 7'd34 ? lead - 7'd10 : 7'd24;
    rmask = (81'd1 << lsb) - 81'd1;
    q = 12'(mag >> lsb);
    guard = |(mag & (81'd1 << (lsb - 7'd1)));
    stk = |(mag & (rmask >> 1));
    rnz = |(mag & rmask);
    inc = roundmode == RM_RNE ? guard & (stk | q[0]) :
          roundmode == RM_RP  ? !s & rnz :
          roundmode == RM_RN  ? s & rnz : 1'b0;
    enc = {lsb - 7'd24, 10'd0} + {5'd0, q} + {16'd0, inc};
    ovf = enc >= 17'h7C00;
    toinf = roundmode == RM_RNE | (roundmode == RM_RP & !s) | (roundmode == RM_RN & s);
    pinf = is_inf(x) | is_inf(ye);
    zinf = is_inf(ze);
    nan = is_nan(x) | is_nan(ye) | is_nan(ze) | (is_inf(x) & is_zero(ye)) |
          (is_zero(x) & is_inf(ye)) | (pinf & zinf & sub);
    result = nan ? CANON_NAN : pinf ? {ps, 15'h7C00} : zinf ? {zs, 15'h7C00} :
             mag == '0 ? {add & sub ? roundmode == RM_RN : ps, 15'd0} :
             ovf ? {s, toinf ? 15'h7C00 : 15'h7BFF} : {s, enc[14:0]};
  end
endmodule

// File: rtl/fma16_rr_arb.sv
// fma16_rr_arb: round-robin grant starting at ptr, ptr moves past each winner
module fma16_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  logic [IDW-1:0] ptr_q, ptr_d, idx;
  // scan downward so the requester nearest ptr overwrites any farther one
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (en && req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_id = idx;
      end
    end
    ptr_d = |gnt ? (gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + IDW'(1)) : ptr_q;
  end
  // pointer register
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fma16_sched.sv
// fma16_sched: round-robin shared access to one fma16 through a two-stage back-pressured pipeline
module fma16_sched import fma16_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][2:0]  req_op,
  input  logic [NREQ-1:0][15:0] req_x,
  input  logic [NREQ-1:0][15:0] req_y,
  input  logic [NREQ-1:0][15:0] req_z,
  input  logic [NREQ-1:0][1:0]  req_rm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_result,
  output logic                  rsp_err,
  output logic [15:0]           op_count
);
  logic s1_valid_q, s1_valid_d, s1_ill_q, s1_ill_d;
  logic [IDW-1:0] s1_id_q, s1_id_d, gnt_id;
  logic [15:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_z_q, s1_z_d;
  fma_ctl_t s1_ctl_q, s1_ctl_d;
  logic [1:0] s1_rm_q, s1_rm_d;
  logic s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [15:0] s2_res_q, s2_res_d, fma_res, op_count_q, op_count_d;
  logic adv, take;
  assign adv = !s2_valid_q | rsp_ready;
  assign take = |req_ready;
  fma16_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .en     ((!s1_valid_q | adv) & !reset),
    .gnt    (req_ready),
    .gnt_id (gnt_id)
  );
  fma16 u_fma (
    .x         (s1_x_q),
    .y         (s1_y_q),
    .z         (s1_z_q),
    .mul       (s1_ctl_q.mul),
    .add       (s1_ctl_q.add),
    .negr      (s1_ctl_q.negr),
    .negz      (s1_ctl_q.negz),
    .roundmode (s1_rm_q),
    .result    (fma_res)
  );
  // S1 captures the granted request, S2 captures the datapath result when the consumer allows
  always_comb begin
    s1_valid_d = take | (s1_valid_q & !adv);
    s1_id_d = take ? gnt_id : s1_id_q;
    s1_x_d = take ? req_x[gnt_id] : s1_x_q;
    s1_y_d = take ? req_y[gnt_id] : s1_y_q;
    s1_z_d = take ? req_z[gnt_id] : s1_z_q;
    s1_rm_d = take ? req_rm[gnt_id] : s1_rm_q;
    s1_ctl_d = take ? op2ctl(op_e'(req_op[gnt_id])) : s1_ctl_q;
    s1_ill_d = take ? req_op[gnt_id] == OP_ILL : s1_ill_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_id_d = adv & s1_valid_q ? s1_id_q : s2_id_q;
    s2_res_d = adv & s1_valid_q ? (s1_ill_q ? CANON_NAN : fma_res) : s2_res_q;
    s2_err_d = adv & s1_valid_q ? s1_ill_q : s2_err_q;
    op_count_d = op_count_q + {15'd0, take};
  end
  // pipeline and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q <= '0;
      s1_x_q <= '0;
      s1_y_q <= '0;
      s1_z_q <= '0;
      s1_rm_q <= '0;
      s1_ctl_q <= '0;
      s1_ill_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q <= '0;
      s2_res_q <= '0;
      s2_err_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q <= s1_id_d;
      s1_x_q <= s1_x_d;
      s1_y_q <= s1_y_d;
      s1_z_q <= s1_z_d;
      s1_rm_q <= s1_rm_d;
      s1_ctl_q <= s1_ctl_d;
      s1_ill_q <= s1_ill_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q <= s2_id_d;
      s2_res_q <= s2_res_d;
      s2_err_q <= s2_err_d;
      op_count_q <= op_count_d;
    end
  end
  assign rsp_valid = s2_valid_q;
  assign rsp_id = s2_id_q;
  assign rsp_result = s2_res_q;
  assign rsp_err = s2_err_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_fma16_sched.sv
// tb_fma16_sched: scoreboard bench with a real-arithmetic reference for the fma16 scheduler
module tb_fma16_sched;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0][2:0] req_op = '0;
  logic [N-1:0][15:0] req_x = '0, req_y = '0, req_z = '0;
  logic [N-1:0][1:0] req_rm = '0;
  logic rsp_valid, rsp_err;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [15:0] rsp_result, op_count;
  typedef struct {
    logic [1:0]  id;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0;
  int inflight = 0, n_acc = 0, rr = 0, pol = 0, acc_cnt = 0, oc0;
  logic [N-1:0] acc_mask;
  logic [15:0] dec_exp [7];

  always #5 clk = ~clk;

  fma16_sched #(.NREQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    v = (h[14:10] == 0) ? real'(h[9:0]) * pow2(-24)
                        : real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  // round an exactly representable real to half precision under the given mode
  function automatic logic [15:0] r2h(input real t, input logic [1:0] rm);
    real a, q, fr;
    int e, ue, enc;
    longint qi;
    logic s, inc, toinf;
    if (t == 0.0) return rm == 2'b11 ? 16'h8000 : 16'h0000;
    s = t < 0.0;
    a = s ? -t : t;
    e = -60;
    while (pow2(e + 1) <= a) e++;
    ue = (e - 10 < -24) ? -24 : e - 10;
    q = a / pow2(ue);
    qi = longint'($floor(q));
    fr = q - real'(qi);
    case (rm)
      2'b01: inc = (fr > 0.5) || (fr == 0.5 && qi[0]);
      2'b10: inc = !s && fr > 0.0;
      2'b11: inc = s && fr > 0.0;
      default: inc = 1'b0;
    endcase
    qi = qi + longint'(inc);
    enc = (ue + 24) * 1024 + int'(qi);
    toinf = rm == 2'b01 || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
    if (enc >= 32'h7C00) return {s, toinf ? 15'h7C00 : 15'h7BFF};
    return {s, 15'(enc)};
  endfunction

  // {mul, add, negr, negz} for each legal opcode
  function automatic logic [3:0] ctl_of(input logic [2:0] op);
    case (op)
      3'd0: return 4'b0100;
      3'd1: return 4'b0101;
      3'd2: return 4'b1000;
      3'd3: return 4'b1100;
      3'd4: return 4'b1101;
      3'd5: return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [16:0] ref_fma(input logic [2:0] op, input logic [15:0] x, y, z,
                                          input logic [1:0] rm);
    real p, t, zv;
    logic [3:0] c;
    if (op == 3'd7) return {1'b1, 16'h7E00};
    c = ctl_of(op);
    p = c[3] ? h2r(x) * h2r(y) : h2r(x);
    zv = (c[1] ^ c[0]) ? -h2r(z) : h2r(z);
    if (c[1]) p = -p;
    t = c[2] ? p + zv : p;
    return {1'b0, r2h(t, rm)};
  endfunction

  function automatic logic [15:0] rnd_h();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  task automatic new_req(input int i);
    req_op[i] = 3'($urandom_range(0, 7));
    req_x[i] = rnd_h();
    req_y[i] = rnd_h();
    req_z[i] = rnd_h();
    req_rm[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] x, y, z);
    req_op[i] = op;
    req_x[i] = x;
    req_y[i] = y;
    req_z[i] = z;
    req_rm[i] = 2'b01;
    req_valid[i] = 1'b1;
  endtask

  // one clock: check grant and counter against the occupancy model, record accepts, then restimulate
  task automatic step();
    logic [N-1:0] er;
    int g, j;
    logic can;
    logic [16:0] r;
    @(negedge clk);
    #1;
    acc_mask = '0;
    if (reset) chk("req_ready_reset", 32'(req_ready), 32'd0);
    else begin
      chk("op_count", 32'(op_count), 32'(n_acc[15:0]));
      can = inflight < 2 || rsp_ready;
      er = '0;
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (g < 0 && can && req_valid[j]) g = j;
      end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (rsp_valid && rsp_ready) inflight--;
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) begin
        r = ref_fma(req_op[i], req_x[i], req_y[i], req_z[i], req_rm[i]);
        sbq.push_back('{id: 2'(i), res: r[15:0], err: r[16]});
        inflight++;
        n_acc++;
        acc_cnt++;
        rr = (i + 1) % N;
        acc_mask[i] = 1'b1;
      end
    end
    @(posedge clk);
    if (reset) begin
      sbq.delete();
      inflight = 0;
      n_acc = 0;
      rr = 0;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && pol == 0) req_valid[i] = 1'b0;
      if (acc_mask[i] && pol == 3) new_req(i);
      if (pol == 2 && (acc_mask[i] || !req_valid[i])) begin
        new_req(i);
        req_valid[i] = 1'($urandom_range(0, 1));
      end
    end
    if (pol == 2) rsp_ready = $urandom_range(0, 3) != 0;
  endtask

  // response monitor: every presented response must equal the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d result=%h, expected no response", rsp_id, rsp_result);
      end else begin
        chk("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
        chk("rsp_result", 32'(rsp_result), 32'(sbq[0].res));
        chk("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    dec_exp[0] = 16'h4400; dec_exp[1] = 16'hC000; dec_exp[2] = 16'h4000; dec_exp[3] = 16'h4500;
    dec_exp[4] = 16'hBC00; dec_exp[5] = 16'hC500; dec_exp[6] = 16'h3C00;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    // single fmul 2.0 * 3.0 from requester 0
    set_req(0, 3'd2, 16'h4000, 16'h4200, 16'h0000);
    step();
    chk("single_gnt", 32'(acc_mask), 32'h1);
    chk("single_lat_n1", 32'(rsp_valid), 32'd0);
    step();
    chk("single_lat_n2", 32'(rsp_valid), 32'd1);
    chk("single_result", 32'(rsp_result), 32'h4600);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_count", 32'(op_count), 32'd1);
    step();
    // fairness: all requesters held valid with 1.0 + 1.0
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 16'h3C00, 16'h3C00, 16'h3C00);
    pol = 1;
    acc_cnt = 0;
    repeat (12) step();
    chk("fair_accepts", 32'(acc_cnt), 32'd12);
    chk("fair_result", 32'(rsp_result), 32'h4000);
    pol = 0;
    req_valid = '0;
    repeat (3) step();
    // backpressure: consumer stalls for five cycles
    rsp_ready = 1'b0;
    new_req(1);
    req_valid[1] = 1'b1;
    pol = 3;
    acc_cnt = 0;
    repeat (5) step();
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    pol = 0;
    repeat (6) step();
    // illegal opcode from requester 2
    oc0 = n_acc;
    set_req(2, 3'd7, 16'h3C00, 16'h3C00, 16'h3C00);
    step();
    chk("ill_gnt", 32'(acc_mask), 32'h4);
    step();
    chk("ill_valid", 32'(rsp_valid), 32'd1);
    chk("ill_result", 32'(rsp_result), 32'h7E00);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_id", 32'(rsp_id), 32'd2);
    chk("ill_count", 32'(op_count), 32'(16'(oc0 + 1)));
    // decode sweep with x=1, y=2, z=3
    for (int op = 0; op < 7; op++) begin
      set_req(3, 3'(op), 16'h3C00, 16'h4000, 16'h4200);
      step();
      chk("dec_gnt", 32'(acc_mask), 32'h8);
      step();
      chk("dec_valid", 32'(rsp_valid), 32'd1);
      chk($sformatf("dec_op%0d", op), 32'(rsp_result), 32'(dec_exp[op]));
    end
    repeat (3) step();
    // randomized traffic with random consumer stalls
    pol = 2;
    repeat (400) step();
    pol = 0;
    rsp_ready = 1'b1;
    repeat (8) step();
    req_valid = '0;
    repeat (3) step();
    // reset with both stages full
    for (int i = 0; i < N; i++) begin
      new_req(i);
      req_valid[i] = 1'b1;
    end
    pol = 1;
    rsp_ready = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_op_count", 32'(op_count), 32'd0);
    rsp_ready = 1'b1;
    step();
    chk("rstmid_first_gnt", 32'(acc_mask), 32'h1);
    req_valid = '0;
    repeat (4) step();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fma16_sched.md
# fma16_sched

Shared-access scheduler for the 16-bit floating-point multiply-accumulate datapath (`fma16`). It arbitrates round-robin among `NREQ` requesters, each presenting a 3-bit opcode and half-precision operands. It decodes the opcode into the datapath's `mul/add/negr/negz` controls and runs a two-stage, back-pressured pipeline around the combinational `fma16`. Each result returns with the requester's ID. It sits between the issue logic and the single `fma16` instance.

## Interface
- `NREQ`, 4 — number of requesters (2..8)
- `IDW`, `$clog2(NREQ)` — response ID width
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `req_valid` in NREQ — requester i has an operation pending
- `req_ready` out NREQ — one-hot grant/accept; a transfer occurs when `req_valid[i] & req_ready[i]`
- `req_op` in NREQ×3 — opcode per requester
- `req_x`, `req_y`, `req_z` in NREQ×16 — operands per requester
- `req_rm` in NREQ×2 — roundmode per requester: 00 rz, 01 rne, 10 rp, 11 rn
- `rsp_valid` out 1 — result available
- `rsp_ready` in 1 — consumer accepts the result
- `rsp_id` out IDW — index of the originating requester
- `rsp_result` out 16 — half-precision result
- `rsp_err` out 1 — the opcode was illegal
- `op_count` out 16 — count of accepted operations, wraps

## Operation
- Opcode decode, giving `{mul,add,negr,negz}`:
  - 0 fadd: 0100
  - 1 fsub: 0101
  - 2 fmul: 1000
  - 3 fmadd: 1100
  - 4 fmsub: 1101
  - 5 fnmadd: 1110
  - 6 fnmsub: 1111
  - 7 illegal
- Illegal opcode: the operation is accepted and occupies a slot. The response carries `rsp_result=16'h7E00` and `rsp_err=1`. The `fma16` output is ignored for that slot.
- Stage S1 (operand register): `s1_valid`, `s1_id`, x/y/z, decoded controls, rm, illegal flag. `fma16` evaluates combinationally from S1.
- Stage S2 (response register): captures the `fma16` result or the canonical NaN, plus the ID and err flag. `rsp_valid` is `s2_valid`.
- Stall rule:
  - S2 loads when `!rsp_valid | rsp_ready`.
  - S1 advances under the same condition.
  - S1 may accept when it is empty or advancing.
- Arbitration:
  - When S1 may accept, grant the first `i` with `req_valid[i]`, scanning from pointer `ptr` upward mod NREQ.
  - `req_ready[i]=1` only for that `i`.
  - When no accept is possible, `req_ready` is all zero.
  - After a grant to `i`, `ptr ← (i+1) mod NREQ`. Otherwise `ptr` holds.
- Requesters hold `req_valid` and their operands stable until accepted. `req_ready` may depend combinationally on `req_valid`.
- `op_count` increments on every accept, including illegal ops. It wraps from 16'hFFFF to 0.

## Timing
- Reset values:
  - `req_ready=0` during reset
  - `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_err=0`
  - `op_count=0`, `ptr=0`, `s1_valid=0`
- Latency: an op accepted in cycle N presents `rsp_valid` in cycle N+2 when there is no backpressure.
- Throughput: one operation per cycle while `rsp_ready=1`.
- Backpressure:
  - While `rsp_valid & !rsp_ready`, the S2 outputs hold exactly.
  - While that condition holds and S1 is full, `req_ready=0`.
  - If S1 is empty, one more op may still be accepted into S1, so up to two ops are in flight.
- Response accept and new request in the same cycle: both transfers occur. S1 moves to S2 and the new op enters S1 with no bubble.
- When only one requester is valid, it is granted every accept cycle regardless of `ptr`.
- Reset asserted mid-operation: in-flight S1/S2 contents are discarded on the next edge and no response is emitted for them. Requesters re-present after reset.

## Structure
- Package `fma16_sched_pkg` holds:
  - `op_e` enum with the opcodes above
  - `fma_ctl_t` struct `{mul,add,negr,negz}`
  - decode function `op2ctl`
  - `CANON_NAN=16'h7E00`
  - roundmode constants `RM_RZ/RM_RNE/RM_RP/RM_RN`
- Sub-module `fma16_rr_arb` (NREQ parameter) provides pointer-based round-robin grant and pointer update.
- One `fma16` instance is driven from the S1 registers.

## Test plan
- Single op: requester 0, op=2 (fmul), x=4000, y=4200, z=0 → `rsp_valid` at N+2, `rsp_id=0`, `rsp_result` equals the `fma16` model for `mul=1,add=0` (6.0 = 4600), `rsp_err=0`, `op_count=1`.
- Fairness: all 4 requesters held valid with fadd 3C00+3C00, `rsp_ready=1` → grants in order 0,1,2,3,0…, one response per cycle, each result 4000.
- Backpressure: back-to-back ops with `rsp_ready=0` for 5 cycles → exactly 2 accepted, `rsp_result`/`rsp_id` stable throughout, `req_ready=0` after the second accept. On release, responses drain in order.
- Illegal opcode: op=7 from requester 2 → `rsp_result=7E00`, `rsp_err=1`, `rsp_id=2`, `op_count` increments.
- Decode sweep: ops 0–6 with x=3C00, y=4000, z=4200 → the controls driven to `fma16` match the decode list for each op, and results match the model.
- Reset mid-flight: assert `reset` with S1 and S2 full → next cycle `rsp_valid=0`, `op_count=0`, and the next grant goes to requester 0.
